// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_e;

  // Width of the shared hold/stage-delay counter: it only has to reach
  // max(HOLD_CYCLES, STAGE_DELAY)-1, but it is never narrower than one bit.
  function automatic int cnt_width(input int hold_cycles, input int stage_delay);
    int m;
    m = (hold_cycles > stage_delay) ? hold_cycles : stage_delay;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Width of the stage index, at least one bit even for a single stage.
  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases synchronously
// after DEPTH rising edges of clk_i.
module rst_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic rstn_sync_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift ones in from the bottom; any low on rstn_i clears the whole chain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], 1'b1};
    end
  end

  assign rstn_sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset generator: synchronizes the raw reset, holds every domain
// in reset for a minimum time, then releases the stages one by one. A
// synchronous software request restarts the hold and is counted.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rstn_out,
  output logic                  rst_done,
  output logic [CNT_W-1:0]      sw_rst_cnt
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY);
  localparam int IW = idx_width(NUM_STAGES);

  localparam logic [CW-1:0]         HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]         DELAY_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]      SW_MAX     = '1;
  localparam logic [NUM_STAGES-1:0] STAGE0     = NUM_STAGES'(1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_STAGES-1:0]   rstn_out_q, rstn_out_d;
  logic                    rst_done_q, rst_done_d;
  logic [CNT_W-1:0]        sw_cnt_q, sw_cnt_d;
  logic                    req_q;
  logic                    rstn_sync;
  logic                    accept;

  rst_sync #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .rstn_sync_o(rstn_sync)
  );

  // A request is honoured only once the synchronized release has happened.
  assign accept = sw_rst_req && (state_q != S_SYNC);

  // Next-state, release schedule and telemetry counter.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rstn_out_d = rstn_out_q;
    rst_done_d = rst_done_q;
    sw_cnt_d   = sw_cnt_q;

    // Count only fresh requests; a level held across states counts once.
    if (accept && !req_q && (sw_cnt_q != SW_MAX)) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end

    if (accept) begin
      // Re-reset everything and hold the counter at zero while requested.
      state_d    = S_HOLD;
      cnt_d      = '0;
      idx_d      = '0;
      rstn_out_d = '0;
      rst_done_d = 1'b0;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          if (rstn_sync) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d      = '0;
            idx_d      = '0;
            rstn_out_d = rstn_out_q | STAGE0;
            if (NUM_STAGES == 1) begin
              rst_done_d = 1'b1;
              state_d    = S_DONE;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_d      = '0;
            idx_d      = idx_q + 1'b1;
            rstn_out_d = rstn_out_q | (STAGE0 << idx_d);
            if (idx_d == IDX_LAST) begin
              rst_done_d = 1'b1;
              state_d    = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // Idle: outputs held until rstn or a software request.
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  // State and output registers; rstn returns everything to the reset values.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the same pre-edge values.
    if (!rstn) begin
      state_q    <= S_SYNC;
      cnt_q      <= '0;
      idx_q      <= '0;
      rstn_out_q <= '0;
      rst_done_q <= 1'b0;
      sw_cnt_q   <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rstn_out_q <= rstn_out_d;
      rst_done_q <= rst_done_d;
      sw_cnt_q   <= sw_cnt_d;
      req_q      <= sw_rst_req;
    end
  end

  assign rstn_out   = rstn_out_q;
  assign rst_done   = rst_done_q;
  assign sw_rst_cnt = sw_cnt_q;

endmodule
